// File: rtl/agc_dsky_pkg.sv
// agc_dsky_pkg: shared row numbers, relay digit codes, scan positions and sign encodings for the DSKY relay decoder
package agc_dsky_pkg;
  localparam logic [3:0] ROW_R3_45  = 4'd1;
  localparam logic [3:0] ROW_R3_23  = 4'd2;
  localparam logic [3:0] ROW_R2R3   = 4'd3;
  localparam logic [3:0] ROW_R2_34  = 4'd4;
  localparam logic [3:0] ROW_R2_12  = 4'd5;
  localparam logic [3:0] ROW_R1_45  = 4'd6;
  localparam logic [3:0] ROW_R1_23  = 4'd7;
  localparam logic [3:0] ROW_R1_1   = 4'd8;
  localparam logic [3:0] ROW_NOUN   = 4'd9;
  localparam logic [3:0] ROW_VERB   = 4'd10;
  localparam logic [3:0] ROW_PROG   = 4'd11;
  localparam logic [3:0] ROW_LIGHTS = 4'd12;
  localparam logic [4:0] CODE_BLANK = 5'b00000;
  localparam logic [4:0] CODE_0     = 5'b10101;
  localparam logic [4:0] CODE_1     = 5'b00011;
  localparam logic [4:0] CODE_2     = 5'b11001;
  localparam logic [4:0] CODE_3     = 5'b11011;
  localparam logic [4:0] CODE_4     = 5'b01111;
  localparam logic [4:0] CODE_5     = 5'b11110;
  localparam logic [4:0] CODE_6     = 5'b11100;
  localparam logic [4:0] CODE_7     = 5'b10011;
  localparam logic [4:0] CODE_8     = 5'b11101;
  localparam logic [4:0] CODE_9     = 5'b11111;
  localparam int         NUM_POS     = 21;
  localparam logic [4:0] POS_PROG    = 5'd0;
  localparam logic [4:0] POS_VERB    = 5'd2;
  localparam logic [4:0] POS_NOUN    = 5'd4;
  localparam logic [4:0] POS_R1      = 5'd6;
  localparam logic [4:0] POS_R2      = 5'd11;
  localparam logic [4:0] POS_R3      = 5'd16;
  localparam logic [4:0] POS_LAST    = 5'd20;
  localparam logic [4:0] FLASH_FIRST = POS_VERB;
  localparam logic [4:0] FLASH_LAST  = POS_NOUN + 5'd1;
  localparam logic [1:0] SIGN_BLANK = 2'b00;
  localparam logic [1:0] SIGN_PLUS  = 2'b01;
  localparam logic [1:0] SIGN_MINUS = 2'b10;
  function automatic logic [1:0] sign_of(input logic plus, input logic minus);
    return plus & ~minus ? SIGN_PLUS : minus & ~plus ? SIGN_MINUS : SIGN_BLANK;
  endfunction
endpackage

// File: rtl/dsky_digit_decode.sv
// dsky_digit_decode: relay code in (code) -> BCD digit out (bcd), dark flag (blank), illegal-code flag (err)
module dsky_digit_decode
  import agc_dsky_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);
  always_comb begin
    bcd = 4'd0;
    blank = 1'b0;
    err = 1'b0;
    case (code)
      CODE_BLANK: blank = 1'b1;
      CODE_0:     bcd = 4'd0;
      CODE_1:     bcd = 4'd1;
      CODE_2:     bcd = 4'd2;
      CODE_3:     bcd = 4'd3;
      CODE_4:     bcd = 4'd4;
      CODE_5:     bcd = 4'd5;
      CODE_6:     bcd = 4'd6;
      CODE_7:     bcd = 4'd7;
      CODE_8:     bcd = 4'd8;
      CODE_9:     bcd = 4'd9;
      default: begin
        blank = 1'b1;
        err = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/dsky_relay_decoder.sv
// dsky_relay_decoder: channel 010 relay words in (ch10_*) -> 21 digit registers scanned out (scan_*), R1-R3 signs, indicator lights, sticky code_err
module dsky_relay_decoder
  import agc_dsky_pkg::*;
#(
  parameter logic [23:0] FLASH_HALF = 24'd800000,
  parameter logic [15:0] SCAN_DIV   = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] ch10_data,
  input  logic        ch10_valid,
  output logic        ch10_ready,
  input  logic        flash_en,
  output logic [4:0]  scan_idx,
  output logic [3:0]  scan_bcd,
  output logic        scan_blank,
  output logic        scan_valid,
  output logic [1:0]  sign_r1,
  output logic [1:0]  sign_r2,
  output logic [1:0]  sign_r3,
  output logic [10:0] ind_lights,
  output logic        code_err
);
  logic [3:0] row, l_bcd, r_bcd;
  logic acc, l_en, r_en, l_blank, r_blank, l_err, r_err, wrap, dark, flip, phase_on;
  logic [4:0] l_pos, r_pos, nidx;
  logic [5:0] s_wr, sgn;
  logic [NUM_POS-1:0][3:0] bcd_q;
  logic [NUM_POS-1:0] blank_q;
  logic [23:0] fcnt;
  logic [15:0] scnt;
  assign row = ch10_data[14:11];
  assign acc = ch10_valid & ch10_ready;
  dsky_digit_decode u_left  (.code(ch10_data[9:5]), .bcd(l_bcd), .blank(l_blank), .err(l_err));
  dsky_digit_decode u_right (.code(ch10_data[4:0]), .bcd(r_bcd), .blank(r_blank), .err(r_err));
  // Rows 11..9 fill positions 0..5 top-down, rows 7..1 fill 7..20; row 8 carries only R1D1.
  always_comb begin
    r_en = row inside {[ROW_R3_45:ROW_PROG]};
    l_en = r_en && row != ROW_R1_1;
    l_pos = row >= ROW_NOUN ? 5'd22 - {row, 1'b0} : 5'd21 - {row, 1'b0};
    r_pos = row == ROW_R1_1 ? POS_R1 : l_pos + 5'd1;
    s_wr = {row == ROW_R3_45, row == ROW_R3_23, row == ROW_R2_34,
            row == ROW_R2_12, row == ROW_R1_45, row == ROW_R1_23};
    flip = fcnt == FLASH_HALF - 24'd1;
    wrap = scnt == SCAN_DIV - 16'd1;
    nidx = scan_idx == POS_LAST ? POS_PROG : scan_idx + 5'd1;
    dark = blank_q[nidx] | (~phase_on & (nidx inside {[FLASH_FIRST:FLASH_LAST]}));
  end
  assign sign_r1 = sign_of(sgn[0], sgn[1]);
  assign sign_r2 = sign_of(sgn[2], sgn[3]);
  assign sign_r3 = sign_of(sgn[4], sgn[5]);
  always_ff @(posedge clk) begin
    if (reset) begin
      ch10_ready <= 1'b1;
      bcd_q <= '0;
      blank_q <= '1;
      sgn <= '0;
      ind_lights <= '0;
      code_err <= 1'b0;
      fcnt <= '0;
      phase_on <= 1'b1;
      scnt <= '0;
      scan_idx <= POS_PROG;
      scan_bcd <= '0;
      scan_blank <= 1'b1;
      scan_valid <= 1'b0;
    end else begin
      ch10_ready <= ~acc;
      if (acc && l_en) begin
        bcd_q[l_pos] <= l_bcd;
        blank_q[l_pos] <= l_blank;
      end
      if (acc && r_en) begin
        bcd_q[r_pos] <= r_bcd;
        blank_q[r_pos] <= r_blank;
      end
      if (acc) sgn <= (sgn & ~s_wr) | (s_wr & {6{ch10_data[10]}});
      if (acc && row == ROW_LIGHTS) ind_lights <= ch10_data[10:0];
      code_err <= code_err | (acc & ((l_en & l_err) | (r_en & r_err)));
      fcnt <= !flash_en || flip ? '0 : fcnt + 24'd1;
      phase_on <= !flash_en || (phase_on ^ flip);
      scan_valid <= wrap;
      scnt <= wrap ? '0 : scnt + 16'd1;
      // Scan samples the digit registers before this edge's write lands.
      if (wrap) begin
        scan_idx <= nidx;
        scan_blank <= dark;
        scan_bcd <= dark ? 4'd0 : bcd_q[nidx];
      end
    end
  end
endmodule

// File: tb/tb_dsky_relay_decoder.sv
// tb_dsky_relay_decoder: directed and random relay words checked against a behavioural DSKY model
module tb_dsky_relay_decoder;
  localparam logic [23:0] FH = 24'd4;
  localparam logic [15:0] SD = 16'd3;
  logic clk = 0, reset = 1, ch10_valid = 0, flash_en = 0;
  logic [14:0] ch10_data = '0;
  logic ch10_ready, scan_blank, scan_valid, code_err;
  logic [4:0] scan_idx;
  logic [3:0] scan_bcd;
  logic [1:0] sign_r1, sign_r2, sign_r3;
  logic [10:0] ind_lights;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dsky_relay_decoder #(.FLASH_HALF(FH), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .ch10_data(ch10_data), .ch10_valid(ch10_valid),
    .ch10_ready(ch10_ready), .flash_en(flash_en), .scan_idx(scan_idx), .scan_bcd(scan_bcd),
    .scan_blank(scan_blank), .scan_valid(scan_valid), .sign_r1(sign_r1), .sign_r2(sign_r2),
    .sign_r3(sign_r3), .ind_lights(ind_lights), .code_err(code_err)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int dec(logic [4:0] c);
    case (c)
      5'b00000: return -1;
      5'b10101: return 0;
      5'b00011: return 1;
      5'b11001: return 2;
      5'b11011: return 3;
      5'b01111: return 4;
      5'b11110: return 5;
      5'b11100: return 6;
      5'b10011: return 7;
      5'b11101: return 8;
      5'b11111: return 9;
      default:  return -2;
    endcase
  endfunction
  int m_dig[21];
  bit m_plus[3], m_minus[3];
  logic [10:0] m_lights;
  bit m_err, m_ready, m_blank, m_sv, m_acc, armed = 0;
  int m_e, m_k, m_idx, m_bcd;
  task automatic put(int p, logic [4:0] c);
    int v = dec(c);
    if (v == -2) m_err = 1;
    m_dig[p] = v < 0 ? -1 : v;
  endtask
  task automatic apply(logic [14:0] w);
    logic [4:0] l = w[9:5], r = w[4:0];
    bit s = w[10];
    case (int'(w[14:11]))
      11: begin put(0, l); put(1, r); end
      10: begin put(2, l); put(3, r); end
      9:  begin put(4, l); put(5, r); end
      8:  put(6, r);
      7:  begin put(7, l); put(8, r); m_plus[0] = s; end
      6:  begin put(9, l); put(10, r); m_minus[0] = s; end
      5:  begin put(11, l); put(12, r); m_plus[1] = s; end
      4:  begin put(13, l); put(14, r); m_minus[1] = s; end
      3:  begin put(15, l); put(16, r); end
      2:  begin put(17, l); put(18, r); m_plus[2] = s; end
      1:  begin put(19, l); put(20, r); m_minus[2] = s; end
      12: m_lights = w[10:0];
      default: ;
    endcase
  endtask
  function automatic int m_sign(int i);
    return (m_plus[i] && !m_minus[i]) ? 1 : (m_minus[i] && !m_plus[i]) ? 2 : 0;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 21; i++) m_dig[i] = -1;
      for (int i = 0; i < 3; i++) begin m_plus[i] = 0; m_minus[i] = 0; end
      m_lights = '0; m_err = 0; m_ready = 1; m_e = 0; m_k = 0;
      m_idx = 0; m_bcd = 0; m_blank = 1; m_sv = 0; armed = 1;
    end else begin
      m_e++;
      m_sv = (m_e % int'(SD)) == 0;
      if (m_sv) begin
        m_idx = (m_e / int'(SD)) % 21;
        m_blank = m_dig[m_idx] < 0 || (((m_k / int'(FH)) % 2 == 1) && m_idx >= 2 && m_idx <= 5);
        m_bcd = m_blank ? 0 : m_dig[m_idx];
      end
      m_k = flash_en ? m_k + 1 : 0;
      m_acc = ch10_valid && m_ready;
      m_ready = !m_acc;
      if (m_acc) apply(ch10_data);
    end
  end
  always @(negedge clk) if (armed) begin
    chk("ready", ch10_ready, m_ready);
    chk("code_err", code_err, m_err);
    chk("lights", ind_lights, m_lights);
    chk("sign_r1", sign_r1, m_sign(0));
    chk("sign_r2", sign_r2, m_sign(1));
    chk("sign_r3", sign_r3, m_sign(2));
    chk("scan_valid", scan_valid, m_sv);
    chk("scan_idx", scan_idx, m_idx);
    chk("scan_bcd", scan_bcd, m_bcd);
    chk("scan_blank", scan_blank, m_blank);
  end
  logic [4:0] legal [11] = '{5'b00000, 5'b10101, 5'b00011, 5'b11001, 5'b11011, 5'b01111,
                             5'b11110, 5'b11100, 5'b10011, 5'b11101, 5'b11111};
  function automatic logic [4:0] pick();
    return ($urandom % 8 == 0) ? 5'($urandom) : legal[$urandom % 11];
  endfunction
  function automatic logic [14:0] rnd_word();
    return {4'($urandom), 1'($urandom), pick(), pick()};
  endfunction
  task automatic send(logic [14:0] w);
    ch10_valid = 1;
    ch10_data = w;
    @(negedge clk);
    ch10_valid = 0;
    ch10_data = 15'($urandom);
  endtask
  task automatic sendc(logic [14:0] w);
    send(w);
    chk("rdy_lo", ch10_ready, 0);
    @(negedge clk);
    chk("rdy_hi", ch10_ready, 1);
  endtask
  task automatic wait_pos(int p, int exp, string tag);
    int n = 0;
    while (!(scan_valid && scan_idx == 5'(p)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, n < 200, 1);
    chk(tag, scan_bcd, exp);
    chk({tag, "_lit"}, scan_blank, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", ch10_ready, 1);
    chk("rst_err", code_err, 0);
    chk("rst_lights", ind_lights, 0);
    chk("rst_sign", {sign_r1, sign_r2, sign_r3}, 0);
    chk("rst_idx", scan_idx, 0);
    chk("rst_blank", scan_blank, 1);
    chk("rst_bcd", scan_bcd, 0);
    chk("rst_sv", scan_valid, 0);
    reset = 0;
    sendc(15'o51563);
    chk("err_clean", code_err, 0);
    wait_pos(2, 3, "verb_d1");
    wait_pos(3, 7, "verb_d2");
    sendc(15'o36171);
    chk("r1_plus", sign_r1, 2'b01);
    wait_pos(7, 1, "r1d2");
    wait_pos(8, 2, "r1d3");
    sendc(15'o32000);
    chk("r1_both", sign_r1, 2'b00);
    sendc(15'o44040);
    chk("err_set", code_err, 1);
    sendc(15'o51563);
    chk("err_sticky", code_err, 1);
    sendc(15'o60525);
    chk("lights_set", ind_lights, 11'o525);
    sendc(15'o74321);
    chk("row15_lights", ind_lights, 11'o525);
    chk("row15_err", code_err, 1);
    n = 0;
    ch10_valid = 1;
    for (int i = 0; i < 10; i++) begin
      ch10_data = rnd_word();
      if (ch10_ready) n++;
      @(negedge clk);
    end
    ch10_valid = 0;
    chk("b2b_accepts", n, 5);
    @(negedge clk);
    send(15'o36171);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_ready", ch10_ready, 1);
    chk("mid_err", code_err, 0);
    chk("mid_lights", ind_lights, 0);
    chk("mid_sign", sign_r1, 0);
    chk("mid_blank", scan_blank, 1);
    chk("mid_idx", scan_idx, 0);
    sendc(15'o51563);
    sendc(15'o46347);
    flash_en = 1;
    repeat (300) @(negedge clk);
    flash_en = 0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 600) == 0;
      if ($urandom % 64 == 0) flash_en = ~flash_en;
      ch10_valid = 1'($urandom);
      ch10_data = rnd_word();
      @(negedge clk);
    end
    reset = 0;
    ch10_valid = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsky_relay_decoder.md
Name: dsky_relay_decoder

Overview:
- Display-side responder for the AGC output channel 010 relay-word protocol.
- Accepts the 15-bit relay words the CPU writes to channel 010 and decodes the 5-bit relay digit codes into BCD.
- Holds the 21 DSKY digit registers, the R1/R2/R3 sign state and the indicator-light latch.
- Applies VERB/NOUN flash timing and time-multiplexes the digits onto a scan bus for the display driver. Sits between the AGC I/O channel logic and the DSKY panel driver.

Parameters:
- FLASH_HALF, 24'd800000: clk cycles per flash half-period (on/off phase length).
- SCAN_DIV, 16'd1000: clk cycles per scan position.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ch10_data  in  15  relay word, AGC bit15..bit1 mapped to [14:0].
- ch10_valid  in  1  CPU presents a word.
- ch10_ready  out  1  block can accept a word.
- flash_en  in  1  channel 011 bit 6; enables VERB/NOUN flashing.
- scan_idx  out  5  digit position 0..20.
- scan_bcd  out  4  BCD value of that position.
- scan_blank  out  1  position is dark.
- scan_valid  out  1  one-cycle pulse when scan outputs change.
- sign_r1  out  2  sign of R1: 00 blank, 01 plus, 10 minus.
- sign_r2  out  2  sign of R2, same encoding.
- sign_r3  out  2  sign of R3, same encoding.
- ind_lights  out  11  indicator latch from row 12.
- code_err  out  1  sticky: an illegal digit code was received.

Behaviour:
- Reset (synchronous, active-high, takes priority over every other event in the same cycle):
  - all digits blank, all sign bits clear, ind_lights=0, code_err=0;
  - ch10_ready=1;
  - flash phase=on, flash counter=0;
  - scan_idx=0, scan_valid=0, scan_bcd=0, scan_blank=1.
- Reset asserted mid-word discards the word and all state.
- Handshake: a word is accepted in cycle N when ch10_valid & ch10_ready.
  - Registers update at the N+1 edge.
  - ch10_ready is 0 in cycle N+1 and returns to 1 in cycle N+2. Maximum rate is one word per 2 cycles.
  - ch10_data need only be stable in cycle N.
- Word fields: row=[14:11], special=[10], left=[9:5], right=[4:0].
- Digit code map: 00000 blank; 10101=0, 00011=1, 11001=2, 11011=3, 01111=4, 11110=5, 11100=6, 10011=7, 11101=8, 11111=9.
  - Any other code: that digit goes blank and code_err is set (sticky until reset).
- Row map (left digit, right digit, special bit):
  - 11: PROG D1, PROG D2.
  - 10: VERB D1, VERB D2.
  - 9: NOUN D1, NOUN D2.
  - 8: right = R1D1; left and special ignored (no error check on left).
  - 7: R1D2, R1D3; special = +R1.
  - 6: R1D4, R1D5; special = -R1.
  - 5: R2D1, R2D2; special = +R2.
  - 4: R2D3, R2D4; special = -R2.
  - 3: R2D5, R3D1; special ignored.
  - 2: R3D2, R3D3; special = +R3.
  - 1: R3D4, R3D5; special = -R3.
  - 12: ind_lights <= data[10:0]; no digit decode.
  - 0, 13, 14, 15: word accepted and discarded; no state change, no error.
- Sign bits are written by their row only; each write overwrites that bit. Sign output:
  - plus only -> 01;
  - minus only -> 10;
  - both or neither -> 00.
- Flash:
  - While flash_en=1, the counter counts 0..FLASH_HALF-1, then wraps and toggles phase.
  - While flash_en=0, counter=0 and phase=on.
  - In the off phase, VERB and NOUN positions scan out as blank. Stored digits are unaffected.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, scan_idx advances (20 wraps to 0) and scan_valid pulses for one cycle.
  - scan_bcd and scan_blank are registered together with scan_idx and reflect digit state as of that edge.
  - Position order: 0-1 PROG, 2-3 VERB, 4-5 NOUN, 6-10 R1D1..D5, 11-15 R2D1..D5, 16-20 R3D1..D5.
  - Blank positions output scan_bcd=0.
- A word write and a scan advance in the same cycle: the scan samples the pre-write digit values.

Decomposition:
- Package agc_dsky_pkg:
  - row number constants (ROW_PROG=11 ... ROW_LIGHTS=12);
  - the eleven relay digit codes;
  - scan position constants;
  - sign encoding constants.
- Sub-module dsky_digit_decode: combinational 5-bit code -> {bcd[3:0], blank, err}. Instantiated twice, for the left and right fields.

Test Plan:
- Reset, then ch10_data=15'o51563 (row 10, 3/7) -> ch10_ready=0 next cycle and 1 the cycle after; scan position 2 = bcd 3, position 3 = bcd 7, code_err=0.
- 15'o36171 (row 7: +R1, R1D2=1, R1D3=2) -> sign_r1=01, positions 7/8 = 1/2; then 15'o32000 -> sign_r1=00 (both set), R1D4/R1D5 blank.
- 15'o44040 (row 9, left code 00001) -> code_err=1 and stays 1; NOUN D1 blank; a subsequent legal word leaves code_err=1 until reset.
- flash_en=1 with FLASH_HALF=4 -> VERB/NOUN scan blank for 4 cycles, shown for 4 cycles, repeating; flash_en=0 -> digits shown continuously.
- Row 12 word 15'o60525 -> ind_lights=11'o525; row 15 word -> no state change, ready still drops for one cycle.
- Hold ch10_valid high with back-to-back words -> one accept every 2 cycles. Assert reset in the cycle after an accept -> all outputs at reset values next edge.
